// File: rtl/e_mdu_pkg.sv
// Shared MD-class definitions: op encodings used by the MDU, decoder and hazard unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMfhi  = 4'd5,
    MdMflo  = 4'd6,
    MdMthi  = 4'd7,
    MdMtlo  = 4'd8
  } md_op_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: 64-bit signed/unsigned products and
// signed/unsigned quotient/remainder (zero outputs for a zero divisor).
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product_s,
  output logic [63:0] product_u,
  output logic [31:0] quot_s,
  output logic [31:0] rem_s,
  output logic [31:0] quot_u,
  output logic [31:0] rem_u
);

  logic signed [63:0] a_ext, b_ext;
  logic               a_neg, b_neg, b_zero;
  logic        [31:0] a_mag, b_mag, q_mag, r_mag;

  assign a_ext     = $signed({{32{a[31]}}, a});
  assign b_ext     = $signed({{32{b[31]}}, b});
  assign product_s = a_ext * b_ext;
  assign product_u = {32'd0, a} * {32'd0, b};

  assign b_zero = (b == 32'd0);
  assign quot_u = b_zero ? 32'd0 : a / b;
  assign rem_u  = b_zero ? 32'd0 : a % b;

  // Magnitude division keeps 0x80000000 / -1 well defined: |a| fits in 32 bits unsigned.
  assign a_neg  = a[31];
  assign b_neg  = b[31];
  assign a_mag  = a_neg ? (32'd0 - a) : a;
  assign b_mag  = b_neg ? (32'd0 - b) : b;
  assign q_mag  = b_zero ? 32'd0 : a_mag / b_mag;
  assign r_mag  = b_zero ? 32'd0 : a_mag % b_mag;
  assign quot_s = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem_s  = a_neg ? (32'd0 - r_mag) : r_mag;

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: accepts MD ops, models latency with a busy
// counter, and owns the architectural HI/LO registers.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int unsigned CntW = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic            skip_wb_q, skip_wb_d;

  logic [63:0] product_s, product_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  md_op_e      op;

  assign op   = md_op_e'(md_op);
  assign busy = (cnt_q != '0);

  mdu_arith u_arith (
    .a         (rs_data),
    .b         (rt_data),
    .product_s (product_s),
    .product_u (product_u),
    .quot_s    (quot_s),
    .rem_s     (rem_s),
    .quot_u    (quot_u),
    .rem_u     (rem_u)
  );

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    tmp_hi_d  = tmp_hi_q;
    tmp_lo_d  = tmp_lo_q;
    skip_wb_d = skip_wb_q;
    if (flush) begin
      cnt_d     = '0;
      tmp_hi_d  = 32'd0;
      tmp_lo_d  = 32'd0;
      skip_wb_d = 1'b0;
    end else if (busy) begin
      // Any start while busy is dropped here; the hazard unit must have stalled it.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1) && !skip_wb_q) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end
    end else if (start) begin
      case (op)
        MdMult: begin
          {tmp_hi_d, tmp_lo_d} = product_s;
          skip_wb_d            = 1'b0;
          cnt_d                = CntW'(MULT_CYCLES);
        end
        MdMultu: begin
          {tmp_hi_d, tmp_lo_d} = product_u;
          skip_wb_d            = 1'b0;
          cnt_d                = CntW'(MULT_CYCLES);
        end
        MdDiv: begin
          tmp_lo_d  = quot_s;
          tmp_hi_d  = rem_s;
          skip_wb_d = (rt_data == 32'd0);
          cnt_d     = CntW'(DIV_CYCLES);
        end
        MdDivu: begin
          tmp_lo_d  = quot_u;
          tmp_hi_d  = rem_u;
          skip_wb_d = (rt_data == 32'd0);
          cnt_d     = CntW'(DIV_CYCLES);
        end
        MdMthi:  hi_d = rs_data;
        MdMtlo:  lo_d = rs_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (op)
      MdMfhi:  md_out = hi_q;
      MdMflo:  md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      tmp_hi_q  <= 32'd0;
      tmp_lo_q  <= 32'd0;
      skip_wb_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      tmp_hi_q  <= tmp_hi_d;
      tmp_lo_q  <= tmp_lo_d;
      skip_wb_q <= skip_wb_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO pairs are queued at issue and popped
// once the unit goes idle, then read back through MFHI/MFLO.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  e_mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse, driven after a negedge; returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'(MdNone);
  endtask

  // Counts negedges on which busy is high; bounded so a stuck unit cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    md_op = 4'(MdMfhi);
    #1 hi = md_out;
    md_op = 4'(MdMflo);
    #1 lo = md_out;
    md_op = 4'(MdNone);
  endtask

  task automatic push(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.tag = tag;
    e.hi  = hi;
    e.lo  = lo;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [31:0] hi, lo;
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected >=1");
      return;
    end
    e = sb.pop_front();
    read_hilo(hi, lo);
    check({e.tag, "_hi"}, hi, e.hi);
    check({e.tag, "_lo"}, lo, e.lo);
  endtask

  initial begin
    int          n;
    logic [31:0] hi, lo;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    read_hilo(hi, lo);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1. Reset mid-MULT at cnt==3
    issue(4'(MdMthi), 32'h0000_0011, 32'd0);
    issue(4'(MdMult), 32'h0000_1000, 32'h0000_1000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    read_hilo(hi, lo);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_after_busy", 32'(busy), 32'd0);
    push("rst_no_wb", 32'd0, 32'd0);
    sb_check();

    // 2. MULT / MULTU
    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(4'(MdMult), 32'hFFFF_FFFE, 32'h0000_0003);
    count_busy(n);
    check("mult_busy_cycles", 32'(n), 32'd5);
    sb_check();
    push("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    issue(4'(MdMultu), 32'hFFFF_FFFE, 32'h0000_0003);
    count_busy(n);
    check("multu_busy_cycles", 32'(n), 32'd5);
    sb_check();

    // 3. DIV / DIVU by zero
    push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'(MdDiv), 32'hFFFF_FFF9, 32'h0000_0002);
    count_busy(n);
    check("div_busy_cycles", 32'(n), 32'd10);
    sb_check();
    push("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'(MdDivu), 32'h0000_0007, 32'h0000_0000);
    count_busy(n);
    check("divu0_busy_cycles", 32'(n), 32'd10);
    sb_check();

    // 4. MTHI/MFHI, MTLO/MFLO
    issue(4'(MdMthi), 32'h1234_5678, 32'd0);
    check("mthi_busy", 32'(busy), 32'd0);
    md_op = 4'(MdMfhi);
    #1 check("mfhi", md_out, 32'h1234_5678);
    md_op = 4'(MdNone);
    #1 check("md_out_none", md_out, 32'd0);
    issue(4'(MdMtlo), 32'hA5A5_A5A5, 32'd0);
    check("mtlo_busy", 32'(busy), 32'd0);
    md_op = 4'(MdMflo);
    #1 check("mflo", md_out, 32'hA5A5_A5A5);
    md_op = 4'(MdNone);

    // 5. Flush on the 3rd busy cycle, then start+flush together
    issue(4'(MdMult), 32'h0000_0064, 32'h0000_00C8);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    push("flush_hold", 32'h1234_5678, 32'hA5A5_A5A5);
    sb_check();
    flush = 1'b1;
    issue(4'(MdMult), 32'h0000_0003, 32'h0000_0003);
    check("start_flush_mult_busy", 32'(busy), 32'd0);
    issue(4'(MdMthi), 32'hDEAD_BEEF, 32'd0);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    push("start_flush_hold", 32'h1234_5678, 32'hA5A5_A5A5);
    sb_check();

    // 6. DIV issued while MULT busy is dropped; signed overflow divide
    push("mult_protect", 32'h0000_0000, 32'h0000_002A);
    issue(4'(MdMult), 32'h0000_0007, 32'h0000_0006);
    issue(4'(MdDiv), 32'h0000_0064, 32'h0000_0003);
    count_busy(n);
    check("mult_protect_rest", 32'(n), 32'd4);
    repeat (12) @(negedge clk);
    sb_check();
    push("div_ovf", 32'h0000_0000, 32'h8000_0000);
    issue(4'(MdDiv), 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check("div_ovf_busy_cycles", 32'(n), 32'd10);
    sb_check();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
